// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: operation codes, FSM states, constants.
// Optional build macro MDU_FAST_MUL_EN (see mult_div_unit.sv) needs nothing from here.
package mdu_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    // Sliced to WIDTH by the user; wide enough for any operand width up to 64.
    localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/mdu_sign_fix.sv
// Final sign correction of the unsigned raw result into architectural {hi, lo}.
// Multiply: whole product negated on sign mismatch. Divide: quotient and remainder fixed separately.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] raw,
    input  logic               sign_a,
    input  logic               sign_b,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] result
);

    always_comb begin
        result = raw;
        if (is_div) begin
            result[WIDTH-1:0]       = (sign_a ^ sign_b) ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
            result[2*WIDTH-1:WIDTH] = sign_a ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
        end else if (sign_a ^ sign_b) begin
            result = -raw;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage iterative multiply/divide unit owning HI/LO; MTHI/MTLO complete in one cycle.
// Build macro MDU_FAST_MUL_EN: MULT/MULTU skip CALC and use a single-cycle multiplier in FIX.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t         state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc, acc_step, raw, fixed;
    logic               is_div, sign_a, sign_b, div0;
    logic               is_md, is_mul, is_signed, accept;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;

    always_comb begin
        is_md     = 1'b0;
        is_mul    = 1'b0;
        is_signed = 1'b0;
        case (op)
            MULT:    begin is_md = 1'b1; is_mul = 1'b1; is_signed = 1'b1; end
            MULTU:   begin is_md = 1'b1; is_mul = 1'b1; end
            DIV:     begin is_md = 1'b1; is_signed = 1'b1; end
            DIVU:    is_md = 1'b1;
            default: ;
        endcase
    end

    // A start is only honoured in IDLE and never in the same cycle as cancel.
    assign accept = (state == IDLE) && start && !cancel;
    assign abs_a  = (is_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b  = (is_signed && b[WIDTH-1]) ? -b : b;
    assign busy   = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && is_md) begin
`ifdef MDU_FAST_MUL_EN
                    state_next = is_mul ? FIX : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (cancel)
                    state_next = IDLE;
                else if (cnt == '0)
                    state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // acc = {upper, lower}: product accumulator for multiply, {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        div_trial = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, opb};
        if (!is_div)
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

`ifdef MDU_FAST_MUL_EN
    assign raw = is_div ? acc : ({{WIDTH{1'b0}}, acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, opb});
`else
    assign raw = acc;
`endif

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .raw    (raw),
        .sign_a (sign_a),
        .sign_b (sign_b),
        .is_div (is_div),
        .result (fixed)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            opb    <= '0;
            acc    <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_md) begin
                        is_div <= !is_mul;
                        sign_a <= is_signed & a[WIDTH-1];
                        sign_b <= is_signed & b[WIDTH-1];
                        opb    <= abs_b;
                        acc    <= {{WIDTH{1'b0}}, abs_a};
                        div0   <= !is_mul && (b == '0);
                        cnt    <= CNT_W'(WIDTH - 1);
                    end else if (accept && op == MTHI) begin
                        hi <= a;
                    end else if (accept && op == MTLO) begin
                        lo <= a;
                    end
                end
                CALC: begin
                    if (!cancel) begin
                        acc <= acc_step;
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    // Divide by zero keeps hi = a via the remainder path; only lo needs forcing.
                    if (!cancel) begin
                        hi   <= fixed[2*WIDTH-1:WIDTH];
                        lo   <= div0 ? DIV0_LO[WIDTH-1:0] : fixed[WIDTH-1:0];
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized scoreboard bench for mult_div_unit with a 64-bit arithmetic reference model.
// Honours MDU_FAST_MUL_EN for the expected multiply latency.
module tb_mult_div_unit;
  import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;
  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];
  int          exp_cyc_q[$];

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el);
    longint      sx, sy, p, q, r;
    logic [63:0] up, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    eh = mdl_hi;
    el = mdl_lo;
    case (o)
      MULT:  begin p = sx * sy; {eh, el} = p; end
      MULTU: begin up = {32'b0, x} * {32'b0, y}; {eh, el} = up; end
      DIV: begin
        if (y == 32'd0) begin eh = x; el = 32'hFFFF_FFFF; end
        else begin q = sx / sy; r = sx % sy; el = q[31:0]; eh = r[31:0]; end
      end
      DIVU: begin
        if (y == 32'd0) begin eh = x; el = 32'hFFFF_FFFF; end
        else begin uq = {32'b0, x} / {32'b0, y}; ur = {32'b0, x} % {32'b0, y}; el = uq[31:0]; eh = ur[31:0]; end
      end
      default: ;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Issue a mul/div op, push its expected result, and track busy length; optionally
  // try to sneak an MTLO in while the op is in flight (must be ignored).
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit intrude);
    logic [31:0] eh, el;
    int lat, n, guard;
    lat = (FAST && (o == MULT || o == MULTU)) ? 1 : 33;
    model(o, x, y, eh, el);
    exp_hi_q.push_back(eh);
    exp_lo_q.push_back(el);
    exp_cyc_q.push_back(cyc + 1 + lat);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    guard = 0;
    while (busy && guard < 100) begin
      n++;
      if (intrude && n == 4) begin start = 1'b1; op = MTLO; a = 32'd1; end
      else start = 1'b0;
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check("busy_len", n, lat);
    mdl_hi = eh;
    mdl_lo = el;
    @(negedge clk);
  endtask

  task automatic move_to(input logic [2:0] o, input logic [31:0] x);
    start = 1'b1; op = o; a = x;
    @(negedge clk);
    start = 1'b0;
    if (o == MTHI) mdl_hi = x;
    if (o == MTLO) mdl_lo = x;
    check("mt_busy", {31'b0, busy}, 32'd0);
    check("mt_hi", hi, mdl_hi);
    check("mt_lo", lo, mdl_lo);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_hi_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected act=done exp=no_done cyc=%0d", cyc);
      end else begin
        check("res_hi", hi, exp_hi_q.pop_front());
        check("res_lo", lo, exp_lo_q.pop_front());
        check("done_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [2:0]  d_op[9] = '{MULTU, MULT, DIV, DIVU, DIV, DIVU, DIV, MULT, DIVU};
  logic [31:0] d_a[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
                           32'h0000_1234, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [31:0] d_b[9]  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF,
                           32'd0, 32'd0, 32'h8000_0000, 32'd1};

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_op(d_op[i], d_a[i], d_b[i], 1'b0);

    // cancel mid-divide: hi/lo untouched, no done, busy drops next cycle
    move_to(MTHI, 32'hA5A5_A5A5);
    start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("cancel_busy_before", {31'b0, busy}, 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy_after", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("cancel_hi", hi, 32'hA5A5_A5A5);
    check("cancel_lo", lo, mdl_lo);

    // MTLO issued while a MULT is in flight must be dropped
    run_op(MULT, 32'd12345, 32'hFFFF_FF00, 1'b1);
    check("intrude_lo", lo, mdl_lo);

    // undefined op code and start-with-cancel are both ignored
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("badop_busy", {31'b0, busy}, 32'd0);
    start = 1'b1; cancel = 1'b1; op = MTHI; a = 32'h1357_9BDF;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("startcancel_hi", hi, mdl_hi);
    check("startcancel_busy", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(ro, ra, rb, 1'b0);
    end

    // async reset during CALC clears everything without a clock edge
    move_to(MTHI, 32'h1111_1111);
    move_to(MTLO, 32'h2222_2222);
    start = 1'b1; op = DIVU; a = 32'd99; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    mdl_hi = '0;
    mdl_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("post_arst_hi", hi, 32'd0);

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (3) @(negedge clk);
    check("queue_empty", exp_hi_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
